// File: rtl/count_sweep_ctrl.sv
// Sequencer that drives a shared up/down counter through repeated 0 -> peak -> 0 sweeps.
// Latency: accepted start to first cnt_en is 2 cycles; each sweep with peak T takes 2T+2 cycles.
// Backpressure: none; start is only taken in IDLE and abort only while busy, otherwise ignored.
module count_sweep_ctrl #(
    parameter int WIDTH = 3,
    parameter int REP_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic [REP_W-1:0] reps_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             cnt_clr_o,
    output logic             cnt_en_o,
    output logic             cnt_mode_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [REP_W-1:0] sweeps_done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_UP     = 3'd2,
        S_DOWN   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic [REP_W-1:0]   sweeps_q, sweeps_d;
    logic               aborted_q, aborted_d;

    logic               busy_state;
    logic               at_peak;
    logic               at_zero;
    logic [REP_W-1:0]   sweeps_inc;

    // >= rather than == so a counter that somehow overshoots still turns around.
    assign at_peak    = (count_i >= target_q);
    assign at_zero    = (count_i == '0);
    assign sweeps_inc = sweeps_q + REP_W'(1);
    assign busy_state = (state_q == S_CLEAR) || (state_q == S_UP) || (state_q == S_DOWN);

    // Next-state and latched-parameter computation; abort overrides any busy-state transition.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        reps_d    = reps_q;
        sweeps_d  = sweeps_q;
        aborted_d = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    target_d  = target_i;
                    reps_d    = reps_i;
                    sweeps_d  = '0;
                    aborted_d = 1'b0;
                    // A zero peak or zero repeat count has no work: report done at once.
                    if ((target_i == '0) || (reps_i == '0)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_UP;
            end
            S_UP: begin
                if (at_peak) begin
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                if (at_zero) begin
                    // A sweep completes when the counter is back at zero; this
                    // bookkeeping still happens if abort arrives in the same cycle.
                    sweeps_d = sweeps_inc;
                    if (sweeps_inc == reps_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_UP;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (busy_state && abort_i) begin
            state_d   = S_FINISH;
            aborted_d = 1'b1;
        end
    end

    // State and latched-parameter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            reps_q    <= '0;
            sweeps_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            reps_q    <= reps_d;
            sweeps_q  <= sweeps_d;
            aborted_q <= aborted_d;
        end
    end

    // Counter control decode: clear on reset or CLEAR, never step past the peak or below zero,
    // and freeze the counter in the cycle an abort is taken so it keeps its value.
    always_comb begin
        cnt_clr_o  = reset_i || ((state_q == S_CLEAR) && !abort_i);
        cnt_en_o   = 1'b0;
        cnt_mode_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        if (!reset_i) begin
            busy_o     = busy_state;
            done_o     = (state_q == S_FINISH);
            cnt_mode_o = (state_q == S_UP);
            if (!abort_i) begin
                cnt_en_o = ((state_q == S_UP) && !at_peak) ||
                           ((state_q == S_DOWN) && !at_zero);
            end
        end
    end

    assign aborted_o     = aborted_q;
    assign sweeps_done_o = sweeps_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl: behavioural counter plus a cycle-indexed sweep timeline model.
// Latency: expectations are indexed by cycles after the start-sampling edge.
// Backpressure: none; inputs are driven on the falling edge and outputs checked 1ns later.
module tb_count_sweep_ctrl;

    localparam int WIDTH = 3;
    localparam int REP_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] target;
    logic [REP_W-1:0] reps;
    logic [WIDTH-1:0] count;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_mode;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [REP_W-1:0] sweeps_done;

    int err_cnt = 0;
    int chk_cnt = 0;

    count_sweep_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .abort_i       (abort),
        .target_i      (target),
        .reps_i        (reps),
        .count_i       (count),
        .cnt_clr_o     (cnt_clr),
        .cnt_en_o      (cnt_en),
        .cnt_mode_o    (cnt_mode),
        .busy_o        (busy),
        .done_o        (done),
        .aborted_o     (aborted),
        .sweeps_done_o (sweeps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controlled counter datapath.
    always @(posedge clk) begin
        if (cnt_clr) begin
            count <= '0;
        end else if (cnt_en) begin
            count <= cnt_mode ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Position within a run of sweeps with peak t, for cycle k >= 2 after start.
    // Each sweep is t up-steps, a turnaround at the peak, t down-steps, a turnaround at zero.
    task automatic sweep_point(input int t, input int k, output int cnt, output int en,
                               output int mode, output int sw);
        int per;
        int j;
        int p;
        per  = 2 * t + 2;
        j    = k - 2;
        p    = j % per;
        sw   = j / per;
        if (p < t) begin
            cnt = p; en = 1; mode = 1;
        end else if (p == t) begin
            cnt = t; en = 0; mode = 1;
        end else if (p <= 2 * t) begin
            cnt = 2 * t + 1 - p; en = 1; mode = 0;
        end else begin
            cnt = 0; en = 0; mode = 0;
        end
    endtask

    // One start request and its whole run; abort_k / xstart_k / reset_k = 0 means unused.
    task automatic run(input int t, input int r, input int abort_k, input int xstart_k,
                       input int reset_k);
        bit zero;
        int per;
        int fin_k;
        int cnt;
        int en;
        int mode;
        int sw;
        int a_cnt;
        int a_sw;
        int exp_sw;
        int exp_ab;
        int exp_cnt;
        zero  = (t == 0) || (r == 0);
        per   = 2 * t + 2;
        fin_k = zero ? 1 : ((abort_k != 0) ? abort_k + 1 : 2 + r * per);
        a_cnt = 0;
        a_sw  = 0;
        exp_cnt = 0;

        @(negedge clk);
        start  = 1'b1;
        abort  = 1'b0;
        target = WIDTH'(t);
        reps   = REP_W'(r);
        #1;
        check_val("idle_busy", int'(busy), 0);
        check_val("idle_en", int'(cnt_en), 0);

        for (int k = 1; k <= fin_k; k++) begin
            @(negedge clk);
            start  = (k == xstart_k);
            abort  = (k == abort_k);
            reset  = (k == reset_k);
            target = WIDTH'($urandom_range(0, 7));
            reps   = REP_W'($urandom_range(0, 15));
            #1;
            if (k == reset_k) begin
                check_val("rst_clr", int'(cnt_clr), 1);
                check_val("rst_en", int'(cnt_en), 0);
                check_val("rst_busy", int'(busy), 0);
                check_val("rst_done", int'(done), 0);
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                #1;
                check_val("post_rst_count", int'(count), 0);
                check_val("post_rst_sweeps", int'(sweeps_done), 0);
                check_val("post_rst_busy", int'(busy), 0);
                check_val("post_rst_done", int'(done), 0);
                check_val("post_rst_aborted", int'(aborted), 0);
                @(negedge clk);
                #1;
                check_val("post_rst_done2", int'(done), 0);
                return;
            end
            if (k == fin_k) begin
                check_val("fin_done", int'(done), 1);
                check_val("fin_busy", int'(busy), 0);
                check_val("fin_en", int'(cnt_en), 0);
                check_val("fin_clr", int'(cnt_clr), 0);
                if (zero) begin
                    exp_sw = 0; exp_ab = 0;
                end else if (abort_k != 0) begin
                    exp_sw = a_sw; exp_ab = 1; exp_cnt = a_cnt;
                end else begin
                    exp_sw = r; exp_ab = 0; exp_cnt = 0;
                end
                check_val("fin_sweeps", int'(sweeps_done), exp_sw);
                check_val("fin_aborted", int'(aborted), exp_ab);
                if (!zero) check_val("fin_count", int'(count), exp_cnt);
            end else if (k == 1) begin
                check_val("clear_clr", int'(cnt_clr), 1);
                check_val("clear_busy", int'(busy), 1);
                check_val("clear_en", int'(cnt_en), 0);
                check_val("clear_done", int'(done), 0);
                check_val("clear_sweeps", int'(sweeps_done), 0);
                check_val("clear_aborted", int'(aborted), 0);
            end else begin
                sweep_point(t, k, cnt, en, mode, sw);
                if (k == abort_k) begin
                    en    = 0;
                    a_cnt = cnt;
                    a_sw  = sw + (((cnt == 0) && (mode == 0)) ? 1 : 0);
                end
                check_val("run_count", int'(count), cnt);
                check_val("run_en", int'(cnt_en), en);
                check_val("run_mode", int'(cnt_mode), mode);
                check_val("run_busy", int'(busy), 1);
                check_val("run_done", int'(done), 0);
                check_val("run_clr", int'(cnt_clr), 0);
                check_val("run_sweeps", int'(sweeps_done), sw);
            end
        end

        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check_val("after_done", int'(done), 0);
        check_val("after_busy", int'(busy), 0);
        check_val("after_en", int'(cnt_en), 0);
        check_val("after_clr", int'(cnt_clr), 0);
        check_val("after_sweeps", int'(sweeps_done), exp_sw);
        check_val("after_aborted", int'(aborted), exp_ab);
        if (!zero) check_val("after_count", int'(count), exp_cnt);
    endtask

    initial begin
        int t;
        int r;
        int sel;
        int per;
        int end_k;
        int ab_k;
        int rs_k;
        int xs_k;

        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        target = '0;
        reps   = '0;

        @(negedge clk);
        #1;
        check_val("reset_clr", int'(cnt_clr), 1);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_en", int'(cnt_en), 0);
        check_val("reset_done", int'(done), 0);
        check_val("reset_sweeps", int'(sweeps_done), 0);
        check_val("reset_aborted", int'(aborted), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rel_clr", int'(cnt_clr), 0);
        check_val("rel_busy", int'(busy), 0);
        check_val("rel_done", int'(done), 0);
        check_val("rel_count", int'(count), 0);

        // Directed cases.
        run(3, 1, 0, 0, 0);
        run(7, 2, 0, 0, 0);
        run(7, 0, 1, 1, 0);
        run(0, 5, 0, 0, 0);
        run(5, 3, 4, 3, 0);
        run(4, 2, 0, 0, 18);
        run(2, 1, 0, 0, 0);

        // Randomised runs: plain, aborted, or interrupted by reset.
        for (int n = 0; n < 40; n++) begin
            t    = $urandom_range(0, 7);
            r    = $urandom_range(0, 6);
            sel  = $urandom_range(0, 9);
            per  = 2 * t + 2;
            ab_k = 0;
            rs_k = 0;
            xs_k = 0;
            if ((t == 0) || (r == 0)) begin
                if (sel >= 5) ab_k = 1;
                if (sel[0]) xs_k = 1;
            end else begin
                end_k = 2 + r * per;
                if (sel < 5) begin
                    if (sel[0]) xs_k = $urandom_range(1, end_k);
                end else if (sel < 8) begin
                    ab_k = $urandom_range(2, end_k - 1);
                    if (sel[0]) xs_k = $urandom_range(1, ab_k + 1);
                end else begin
                    rs_k = $urandom_range(2, end_k - 1);
                    if (sel[0]) xs_k = $urandom_range(1, rs_k - 1);
                end
            end
            run(t, r, ab_k, xs_k, rs_k);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/count_sweep_ctrl.md
Name: count_sweep_ctrl

Overview:
Sequencer for the shared 3-bit up/down count datapath. On a start request it clears the counter, counts up to a programmed peak and back down to zero, and repeats this for a programmed number of sweeps. It then pulses done. It drives the counter's clear, enable and mode lines and watches the counter's count output. It sits between the control logic that issues sweep commands and the counter datapath.

Parameters:
WIDTH, 3, width of counter value and target
REP_W, 4, width of sweep-repeat count and sweep progress output

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  sweep request; accepted only in IDLE
abort  input  1  terminate the current sweep; honoured only while busy
target  input  WIDTH  peak count; sampled into target_q when start is accepted
reps  input  REP_W  number of up/down sweeps; sampled into reps_q when start is accepted
count  input  WIDTH  current value of the controlled counter; counter updates on the edge after cnt_en is high
cnt_clr  output  1  synchronous clear to the counter
cnt_en  output  1  counter advance enable
cnt_mode  output  1  1 = count up, 0 = count down
busy  output  1  high in CLEAR, UP and DOWN
done  output  1  one-cycle completion pulse
aborted  output  1  last run ended by abort; held until the next accepted start
sweeps_done  output  REP_W  completed sweeps in the current or last run

Behaviour:
- States: IDLE, CLEAR, UP, DOWN, FINISH. State is registered; outputs are decoded combinationally from state and count.
- Reset (sync): next state is IDLE; sweeps_done=0, aborted=0, target_q=0, reps_q=0. cnt_clr is high in every cycle reset is high. cnt_en=0, cnt_mode=0, busy=0, done=0.
- IDLE: all outputs low except the held sweeps_done and aborted.
  - start=1: latch target and reps; clear sweeps_done and aborted.
  - If target==0 or reps==0, go to FINISH; otherwise go to CLEAR.
- CLEAR: cnt_clr=1 for exactly one cycle; go to UP.
- UP: cnt_mode=1.
  - If count < target_q: cnt_en=1, stay in UP.
  - If count >= target_q: cnt_en=0 and go to DOWN. This is a one-cycle turnaround. The >= comparison guards against overshoot.
- DOWN: cnt_mode=0.
  - If count != 0: cnt_en=1, stay in DOWN.
  - If count == 0: cnt_en=0 and sweeps_done increments. If the new sweeps_done equals reps_q, go to FINISH; otherwise go to UP.
- FINISH: done=1 for one cycle, busy=0; go to IDLE.
- Latency:
  - Accepted start to first cnt_en: 2 cycles.
  - One full sweep with peak T: 2T+2 cycles (T up, turnaround, T down, turnaround).
  - done is asserted 2 + reps*(2T+2) cycles after the start-sampling edge.
- abort=1 in CLEAR, UP or DOWN: go to FINISH and set aborted=1. The counter is not cleared and keeps its value; sweeps_done holds. abort is ignored in IDLE and FINISH.
- Simultaneous events:
  - start while busy or in FINISH is ignored.
  - abort together with a terminating condition: abort wins and aborted=1, but sweeps_done still increments if DOWN reached count==0 that cycle.
  - reset overrides everything.
- Wrap-around:
  - cnt_en is never asserted up at count==2^WIDTH-1 or down at count==0, so the counter never wraps.
  - sweeps_done does not overflow because it stops at reps_q ≤ 2^REP_W-1.
- Reset mid-operation: IDLE on the next cycle; the counter is cleared via cnt_clr in the same cycle; no done pulse.
- target and reps changing while busy has no effect; only the latched copies are used.

Test Plan:
- Reset held 2 cycles, then released -> busy=0, done=0, cnt_en=0, sweeps_done=0, aborted=0; cnt_clr=1 only while reset is high.
- Counter model; start with target=3, reps=1 -> CLEAR at cycle 1; count sequence 0,1,2,3,3,2,1,0; cnt_en low in the turnaround cycles; done=1 at cycle 10 only; sweeps_done=1.
- target=7, reps=2 -> count peaks at 7 twice and never exceeds 7; sweeps_done steps 0→1→2; single done pulse at cycle 2+2*16=34.
- start with reps=0 (and separately target=0) -> done=1 at cycle 1; cnt_en and cnt_clr never asserted; sweeps_done=0.
- target=5, reps=3: abort when count=2 in UP, plus a start pulse during busy -> next cycle FINISH, done=1, aborted=1, count stays 2; the extra start has no effect.
- target=4, reps=2: reset at count=3 in DOWN of sweep 2 -> next cycle IDLE, count=0, sweeps_done=0, no done pulse; a new start is then accepted normally.
